// File: rtl/stats_pkg.sv
// rtl/stats_pkg.sv - shared selector type, default widths and popcount for switch statistics
package stats_pkg;

  typedef enum logic [1:0] {
    SEL_ACC    = 2'd0,
    SEL_DROP   = 2'd1,
    SEL_DLV    = 2'd2,
    SEL_FLIGHT = 2'd3
  } stat_sel_e;

  localparam int DEF_CNT_WIDTH    = 16;
  localparam int DEF_FLIGHT_WIDTH = 20;

  // Callers zero-extend their mask to 32 bits before calling.
  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + (v[i] ? 1 : 0);
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter whose clear loads the current increment
module sat_counter #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 clr,
  output logic [WIDTH-1:0]     count,
  output logic                 sat_pulse
);

  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;

  // Clearing restarts from this cycle's increment so no event is lost.
  always_comb begin
    base      = clr ? '0 : count;
    sum       = {1'b0, base} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
    sat_pulse = sum[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count <= '0;
    else        count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/switch_stats_unit.sv
// rtl/switch_stats_unit.sv - per-port accept/drop/deliver counters, in-flight balance, snapshot read port
module switch_stats_unit import stats_pkg::*; #(
  parameter int NUM_PORTS    = 4,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int FLIGHT_WIDTH = DEF_FLIGHT_WIDTH,
  parameter int CLR_ON_SNAP  = 0,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] target_in,
  input  logic [NUM_PORTS-1:0]           fifo_full,
  input  logic [NUM_PORTS-1:0]           valid_out,
  input  logic                           snap_req,
  input  logic                           clr_req,
  input  logic                           rd_en,
  input  logic [PW-1:0]                  rd_port,
  input  logic [1:0]                     rd_sel,
  output logic                           rd_valid,
  output logic [FLIGHT_WIDTH-1:0]        rd_data,
  output logic [NUM_PORTS-1:0]           sat_flag,
  output logic                           underflow_err
);

  localparam int WW = $clog2(NUM_PORTS + 1);
  localparam int SW = $clog2(NUM_PORTS * NUM_PORTS + 1);

  logic                    clr_eff;
  logic [WW-1:0]           weight   [NUM_PORTS];
  logic [WW-1:0]           acc_inc  [NUM_PORTS];
  logic [WW-1:0]           drop_inc [NUM_PORTS];
  logic [SW-1:0]           acc_sum;
  logic [CNT_WIDTH-1:0]    live_acc [NUM_PORTS];
  logic [CNT_WIDTH-1:0]    live_drop[NUM_PORTS];
  logic [CNT_WIDTH-1:0]    live_dlv [NUM_PORTS];
  logic [CNT_WIDTH-1:0]    sh_acc   [NUM_PORTS];
  logic [CNT_WIDTH-1:0]    sh_drop  [NUM_PORTS];
  logic [CNT_WIDTH-1:0]    sh_dlv   [NUM_PORTS];
  logic [NUM_PORTS-1:0]    sat_acc, sat_drop, sat_dlv;
  logic [FLIGHT_WIDTH-1:0] flight, sh_flight, fl_next, rd_value;
  logic [FLIGHT_WIDTH:0]   fl_up, fl_diff, fl_dec;
  logic                    fl_under;
  stat_sel_e               sel;

  assign clr_eff = clr_req | ((CLR_ON_SNAP != 0) & snap_req);

  always_comb begin
    acc_sum = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      weight[p]   = WW'(popcount(32'(target_in[p*NUM_PORTS +: NUM_PORTS])));
      acc_inc[p]  = (valid_in[p] && !fifo_full[p]) ? weight[p] : '0;
      drop_inc[p] = (valid_in[p] &&  fifo_full[p]) ? weight[p] : '0;
      acc_sum     = acc_sum + SW'(acc_inc[p]);
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(WW)) u_acc (
      .clk, .rst_n, .inc(acc_inc[p]), .clr(clr_eff), .count(live_acc[p]), .sat_pulse(sat_acc[p]));
    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(WW)) u_drop (
      .clk, .rst_n, .inc(drop_inc[p]), .clr(clr_eff), .count(live_drop[p]), .sat_pulse(sat_drop[p]));
    sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_dlv (
      .clk, .rst_n, .inc(valid_out[p]), .clr(clr_eff), .count(live_dlv[p]), .sat_pulse(sat_dlv[p]));
  end

  // Add first in a widened domain, then subtract; a borrow means the balance went negative.
  always_comb begin
    fl_up    = {1'b0, flight} + (FLIGHT_WIDTH + 1)'(acc_sum);
    fl_dec   = (FLIGHT_WIDTH + 1)'(popcount(32'(valid_out)));
    fl_under = fl_up < fl_dec;
    fl_diff  = fl_up - fl_dec;
    if (fl_under)                  fl_next = '0;
    else if (fl_diff[FLIGHT_WIDTH]) fl_next = '1;
    else                           fl_next = fl_diff[FLIGHT_WIDTH-1:0];
  end

  // A read in a snapshot cycle sees the freshly captured values.
  always_comb begin
    sel      = stat_sel_e'(rd_sel);
    rd_value = '0;
    if (sel == SEL_FLIGHT) begin
      rd_value = snap_req ? flight : sh_flight;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rd_port == PW'(i)) begin
          case (sel)
            SEL_ACC:  rd_value = FLIGHT_WIDTH'(snap_req ? live_acc[i]  : sh_acc[i]);
            SEL_DROP: rd_value = FLIGHT_WIDTH'(snap_req ? live_drop[i] : sh_drop[i]);
            default:  rd_value = FLIGHT_WIDTH'(snap_req ? live_dlv[i]  : sh_dlv[i]);
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flight        <= '0;
      sh_flight     <= '0;
      underflow_err <= 1'b0;
      sat_flag      <= '0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        sh_acc[p]  <= '0;
        sh_drop[p] <= '0;
        sh_dlv[p]  <= '0;
      end
    end else begin
      flight <= fl_next;
      if (fl_under) underflow_err <= 1'b1;
      sat_flag <= (clr_eff ? '0 : sat_flag) | sat_acc | sat_drop | sat_dlv;
      if (snap_req) begin
        sh_flight <= flight;
        for (int p = 0; p < NUM_PORTS; p++) begin
          sh_acc[p]  <= live_acc[p];
          sh_drop[p] <= live_drop[p];
          sh_dlv[p]  <= live_dlv[p];
        end
      end
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_value;
    end
  end

endmodule
